comparator_controller: RTL and testbench

//  Sequences the comparator demux and tracks the best (lowest) hash bit-distance found so far.

---
 rtl/skein_alu_pkg.sv | 18 +
 rtl/comparator_controller.sv | 141 ++++++++++++++
 tb/tb_comparator_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skein_alu_pkg.sv
// Shared definitions for the comparator controller: FSM state encoding,
// default widths and the all-ones score constant used as the "no best yet" value.
package skein_alu_pkg;

  localparam int DEFAULT_DATA_W  = 64;
  localparam int DEFAULT_NONCE_W = 64;
  localparam int DEFAULT_COUNT_W = 32;

  localparam logic [DEFAULT_DATA_W-1:0] SCORE_ALL_ONES = {DEFAULT_DATA_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPARE = 2'd2,
    ST_UPDATE  = 2'd3
  } ctrl_state_t;

endpackage : skein_alu_pkg

// File: rtl/comparator_controller.sv
// Comparator controller: accepts {score, nonce} results, steps the demux
// selects through LOAD/COMPARE, and keeps the lowest score seen so far.
// Optional build macro COMPARATOR_CTRL_THRESHOLD_EN adds threshold_i/done_o:
// once an improvement lands at or below the threshold the controller stops
// accepting results until reset or clear.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a result; accepted score/nonce go to holding regs
// LOAD    | demux passes the bit-counter register (one cycle)
// COMPARE | demux presents the best register; decide strict improvement
// UPDATE  | best registers hold the new result, new_best_o high
module comparator_controller
  import skein_alu_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int NONCE_W = DEFAULT_NONCE_W,
  parameter int COUNT_W = DEFAULT_COUNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               result_valid_i,
  output logic               result_ready_o,
  input  logic [DATA_W-1:0]  result_score_i,
  input  logic [NONCE_W-1:0] result_nonce_i,
  output logic               bit_counter_select_o,
  output logic               comparator_select_o,
  output logic               best_valid_o,
  output logic [DATA_W-1:0]  best_score_o,
  output logic [NONCE_W-1:0] best_nonce_o,
  output logic               new_best_o,
  output logic [COUNT_W-1:0] results_count_o
`ifdef COMPARATOR_CTRL_THRESHOLD_EN
  ,
  input  logic [DATA_W-1:0]  threshold_i,
  output logic               done_o
`endif
);

  ctrl_state_t        state;
  logic [DATA_W-1:0]  held_score;
  logic [NONCE_W-1:0] held_nonce;
  logic               stop_accept;
  logic               accept;
  logic               better;

`ifdef COMPARATOR_CTRL_THRESHOLD_EN
  logic done_q;

  // Sticky done flag: set on leaving UPDATE when the new best is within threshold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
    end else if (clear_i) begin
      done_q <= 1'b0;
    end else if (state == ST_UPDATE && best_score_o <= threshold_i) begin
      done_q <= 1'b1;
    end
  end

  assign done_o      = done_q;
  assign stop_accept = done_q;
`else
  assign stop_accept = 1'b0;
`endif

  // Ready only in IDLE; a clear cycle never accepts, and reset holds ready low.
  assign result_ready_o = (state == ST_IDLE) & ~clear_i & ~rst_i & ~stop_accept;
  assign accept         = result_valid_i & result_ready_o;

  // Strict unsigned improvement; the first result always wins, even all-ones.
  assign better = ~best_valid_o | (held_score < best_score_o);

  // Sequencing FSM with registered selects, best tracking and result counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                <= ST_IDLE;
      held_score           <= '0;
      held_nonce           <= '0;
      best_valid_o         <= 1'b0;
      best_score_o         <= {DATA_W{1'b1}};
      best_nonce_o         <= '0;
      new_best_o           <= 1'b0;
      bit_counter_select_o <= 1'b0;
      comparator_select_o  <= 1'b0;
      results_count_o      <= '0;
    end else if (clear_i) begin
      state                <= ST_IDLE;
      best_valid_o         <= 1'b0;
      best_score_o         <= {DATA_W{1'b1}};
      best_nonce_o         <= '0;
      new_best_o           <= 1'b0;
      bit_counter_select_o <= 1'b0;
      comparator_select_o  <= 1'b0;
      results_count_o      <= '0;
    end else begin
      new_best_o           <= 1'b0;
      bit_counter_select_o <= 1'b0;
      comparator_select_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            held_score           <= result_score_i;
            held_nonce           <= result_nonce_i;
            // Counter saturates rather than wrapping.
            if (results_count_o != {COUNT_W{1'b1}}) begin
              results_count_o <= results_count_o + COUNT_W'(1);
            end
            // LOAD routes the bit-counter register onto the operand path.
            bit_counter_select_o <= 1'b1;
            comparator_select_o  <= 1'b1;
            state                <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Both selects low: demux presents the best register for COMPARE.
          state <= ST_COMPARE;
        end
        ST_COMPARE: begin
          if (better) begin
            best_score_o <= held_score;
            best_nonce_o <= held_nonce;
            best_valid_o <= 1'b1;
            new_best_o   <= 1'b1;
            state        <= ST_UPDATE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : comparator_controller

// File: tb/tb_comparator_controller.sv
// Bench for comparator_controller: directed scenarios plus randomized results,
// checked against a transaction-level reference (running minimum over a queue
// of accepted results, with a per-result cycle timeline derived from latency).
module tb_comparator_controller;

  localparam int DATA_W  = 64;
  localparam int NONCE_W = 64;
  localparam int COUNT_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               valid;
  logic               ready;
  logic [DATA_W-1:0]  score;
  logic [NONCE_W-1:0] nonce;
  logic               bcs;
  logic               cs;
  logic               best_valid;
  logic [DATA_W-1:0]  best_score;
  logic [NONCE_W-1:0] best_nonce;
  logic               new_best;
  logic [COUNT_W-1:0] count;
`ifdef COMPARATOR_CTRL_THRESHOLD_EN
  logic [DATA_W-1:0]  threshold;
  logic               done;
`endif

  comparator_controller #(
    .DATA_W (DATA_W),
    .NONCE_W(NONCE_W),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .clear_i             (clear),
    .result_valid_i      (valid),
    .result_ready_o      (ready),
    .result_score_i      (score),
    .result_nonce_i      (nonce),
    .bit_counter_select_o(bcs),
    .comparator_select_o (cs),
    .best_valid_o        (best_valid),
    .best_score_o        (best_score),
    .best_nonce_o        (best_nonce),
    .new_best_o          (new_best),
    .results_count_o     (count)
`ifdef COMPARATOR_CTRL_THRESHOLD_EN
    ,
    .threshold_i         (threshold),
    .done_o              (done)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: queue of accepted results since reset/clear; the best is the
  // first occurrence of the minimum. Each accepted result occupies a short
  // timeline: cycle +1 load, +2 compare, +3 update pulse if it improved.
  logic [DATA_W-1:0]  acc_score[$];
  logic [NONCE_W-1:0] acc_nonce[$];
  int                 busy_left;   // cycles after accept still busy
  int                 age;         // cycles since last accept
  logic               improved;
  logic [DATA_W-1:0]  ref_best_score;
  logic [NONCE_W-1:0] ref_best_nonce;
  logic               ref_done;
  logic               acc_now;
  int                 edge_n;
  int                 acc_edge;
  int                 pulses;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_flush();
    acc_score.delete();
    acc_nonce.delete();
    busy_left      = 0;
    age            = 99;
    improved       = 1'b0;
    ref_best_score = '1;
    ref_best_nonce = '0;
    ref_done       = 1'b0;
  endtask

  // Called at each rising edge with the inputs that were applied before it.
  task automatic ref_edge();
    logic ref_ready;
    acc_now   = 1'b0;
    ref_ready = (busy_left == 0) && !clear && !ref_done && !rst;
    if (rst || clear) begin
      ref_flush();
      return;
    end
    if (age < 99) age++;
    if (busy_left > 0) begin
      busy_left--;
      // Leaving the update cycle arms the threshold stop.
`ifdef COMPARATOR_CTRL_THRESHOLD_EN
      if (busy_left == 0 && improved && ref_best_score <= threshold) ref_done = 1'b1;
`endif
    end else if (valid && ref_ready) begin
      acc_now  = 1'b1;
      acc_edge = edge_n;
      improved = (acc_score.size() == 0) || (score < ref_best_score);
      acc_score.push_back(score);
      acc_nonce.push_back(nonce);
      if (improved) begin
        ref_best_score = score;
        ref_best_nonce = nonce;
      end
      busy_left = improved ? 3 : 2;
      age       = 0;
    end
  endtask

  task automatic check_outputs();
    logic exp_ready;
    logic pulse_now;
    logic show_new;
    exp_ready = (busy_left == 0) && !clear && !ref_done && !rst;
    pulse_now = improved && (age == 2) && (busy_left == 1);
    // Best registers change together with the pulse, i.e. from age 2 on.
    show_new  = !(improved && age < 2);
    check("ready", 64'(ready), 64'(exp_ready));
    check("bit_counter_select", 64'(bcs), 64'(age == 0));
    if (age == 1) check("comparator_select_in_compare", 64'(cs), 64'd0);
    check("new_best", 64'(new_best), 64'(pulse_now));
    check("count", 64'(count), 64'(acc_score.size()));
    if (show_new) begin
      check("best_valid", 64'(best_valid), 64'(acc_score.size() != 0));
      check("best_score", best_score, ref_best_score);
      check("best_nonce", best_nonce, ref_best_nonce);
    end
`ifdef COMPARATOR_CTRL_THRESHOLD_EN
    check("done", 64'(done), 64'(ref_done));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    ref_edge();
    @(negedge clk);
    check_outputs();
    if (new_best === 1'b1) begin
      pulses++;
      check("latency", 64'(edge_n - acc_edge), 64'd2);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] s, input logic [NONCE_W-1:0] n);
    int guard;
    guard = 0;
    score = s;
    nonce = n;
    valid = 1'b1;
    acc_now = 1'b0;
    while (!acc_now && guard < 20) begin
      tick();
      guard++;
    end
    check("accept_within_bound", 64'(acc_now), 64'd1);
    valid = 1'b0;
    guard = 0;
    while (busy_left != 0 && guard < 20) begin
      tick();
      guard++;
    end
  endtask

  // Independent look at the queue: first minimum, and the count.
  task automatic check_scoreboard(input string tag);
    logic [DATA_W-1:0]  m_s;
    logic [NONCE_W-1:0] m_n;
    m_s = '1;
    m_n = '0;
    for (int i = 0; i < acc_score.size(); i++) begin
      if (i == 0 || acc_score[i] < m_s) begin
        m_s = acc_score[i];
        m_n = acc_nonce[i];
      end
    end
    check({tag, "_score"}, best_score, m_s);
    check({tag, "_nonce"}, best_nonce, m_n);
    check({tag, "_count"}, 64'(count), 64'(acc_score.size()));
  endtask

  initial begin
    int guard;
    int got;
    int p0;
    rst    = 1'b1;
    clear  = 1'b0;
    valid  = 1'b0;
    score  = '0;
    nonce  = '0;
    edge_n = 0;
    acc_edge = 0;
    pulses = 0;
    acc_now = 1'b0;
`ifdef COMPARATOR_CTRL_THRESHOLD_EN
    threshold = '1;
`endif
    ref_flush();

    // Reset values, ready low while reset is asserted.
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_best_score", best_score, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset_best_nonce", best_nonce, 64'd0);
    check("reset_best_valid", 64'(best_valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_selects", 64'({bcs, cs, new_best}), 64'd0);
    rst = 1'b0;
    tick();

    // First result: pulse at accept+3, best 500/7.
    p0 = pulses;
    send(64'd500, 64'd7);
    check("first_pulse", 64'(pulses - p0), 64'd1);
    check("first_best_score", best_score, 64'd500);
    check("first_best_nonce", best_nonce, 64'd7);
    check("first_count", 64'(count), 64'd1);

    // Worse, tie, better.
    p0 = pulses;
    send(64'd600, 64'd8);
    send(64'd500, 64'd9);
    check("tie_keeps_first_nonce", best_nonce, 64'd7);
    check("no_pulse_worse_or_tie", 64'(pulses - p0), 64'd0);
    send(64'd420, 64'd11);
    check("improve_score", best_score, 64'd420);
    check("improve_nonce", best_nonce, 64'd11);
    check("improve_pulse", 64'(pulses - p0), 64'd1);
    check_scoreboard("directed");

    // Clear during LOAD aborts the in-flight result.
    score = 64'd10;
    nonce = 64'd3;
    valid = 1'b1;
    guard = 0;
    acc_now = 1'b0;
    while (!acc_now && guard < 10) begin
      tick();
      guard++;
    end
    valid = 1'b0;
    check("load_cycle_bcs", 64'(bcs), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("clear_best_valid", 64'(best_valid), 64'd0);
    check("clear_best_score", best_score, 64'hFFFF_FFFF_FFFF_FFFF);
    check("clear_count", 64'(count), 64'd0);
    check("clear_ready", 64'(ready), 64'd1);

    // Back-to-back: valid held high for 8 results.
    score = 64'($urandom_range(0, 1000));
    nonce = 64'($urandom);
    valid = 1'b1;
    got   = 0;
    guard = 0;
    while (got < 8 && guard < 100) begin
      tick();
      guard++;
      if (acc_now) begin
        got++;
        score = 64'($urandom_range(0, 1000));
        nonce = 64'($urandom);
      end
    end
    valid = 1'b0;
    guard = 0;
    while (busy_left != 0 && guard < 10) begin
      tick();
      guard++;
    end
    check("b2b_count", 64'(count), 64'd8);
    check_scoreboard("b2b");

    // Randomized results with random gaps and small score range for ties.
    for (int i = 0; i < 40; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      send(64'($urandom_range(0, 300)), {32'($urandom), 32'($urandom)});
    end
    check_scoreboard("random");

    // All-ones score with no prior best is still recorded.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    send('1, 64'd5);
    check("all_ones_valid", 64'(best_valid), 64'd1);
    check("all_ones_nonce", best_nonce, 64'd5);

    // Asynchronous reset in the middle of a result.
    score = 64'd3;
    nonce = 64'd4;
    valid = 1'b1;
    guard = 0;
    acc_now = 1'b0;
    while (!acc_now && guard < 10) begin
      tick();
      guard++;
    end
    valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_best_valid", 64'(best_valid), 64'd0);
    check("async_rst_best_score", best_score, 64'hFFFF_FFFF_FFFF_FFFF);
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_ready", 64'(ready), 64'd0);
    ref_flush();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 64'(ready), 64'd1);

`ifdef COMPARATOR_CTRL_THRESHOLD_EN
    threshold = 64'd400;
    send(64'd420, 64'd1);
    check("thr_not_done", 64'(done), 64'd0);
    send(64'd399, 64'd2);
    check("thr_done", 64'(done), 64'd1);
    check("thr_ready_low", 64'(ready), 64'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("thr_clear_done", 64'(done), 64'd0);
    check("thr_clear_ready", 64'(ready), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_comparator_controller
